// File: rtl/sha_pkg.sv
// Shared constants, state encoding and rotate helpers for the SHA message-schedule datapath.
// Used by w_scheduler and w_sigma.
package sha_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    localparam int W256_BITS = 32;
    localparam int W512_BITS = 64;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // small sigma rotate/shift amounts: s0 = ROTR a ^ ROTR b ^ SHR c, s1 likewise
    localparam int S256_S0_R0 = 7;
    localparam int S256_S0_R1 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R0 = 17;
    localparam int S256_S1_R1 = 19;
    localparam int S256_S1_SH = 10;

    localparam int S512_S0_R0 = 1;
    localparam int S512_S0_R1 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R0 = 19;
    localparam int S512_S1_R1 = 61;
    localparam int S512_S1_SH = 6;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/w_sigma.sv
// Combinational dual-mode small sigma functions; mode 1 = SHA-512, mode 0 = SHA-256.
// In SHA-256 mode only word[31:0] is used and both results have [63:32] = 0.
module w_sigma
    import sha_pkg::*;
(
    input  logic [63:0] word,
    input  logic        mode,
    output logic [63:0] s0,
    output logic [63:0] s1
);

    always_comb begin
        s0 = '0;
        s1 = '0;
        if (mode) begin
            s0 = rotr64(word, S512_S0_R0) ^ rotr64(word, S512_S0_R1) ^ (word >> S512_S0_SH);
            s1 = rotr64(word, S512_S1_R0) ^ rotr64(word, S512_S1_R1) ^ (word >> S512_S1_SH);
        end else begin
            s0 = {32'b0, rotr32(word[31:0], S256_S0_R0) ^ rotr32(word[31:0], S256_S0_R1)
                         ^ (word[31:0] >> S256_S0_SH)};
            s1 = {32'b0, rotr32(word[31:0], S256_S1_R0) ^ rotr32(word[31:0], S256_S1_R1)
                         ^ (word[31:0] >> S256_S1_SH)};
        end
    end

endmodule

// File: rtl/w_scheduler.sv
// SHA message schedule: loads one block, emits W_t per valid/ready handshake (64 or 80 words).
// Registered outputs, W_0 one cycle after start; w_ready low holds window. Macro W_SCHED_SHA512_EN adds SHA-512.
module w_scheduler
    import sha_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [1023:0] block_in,
    input  logic          w_ready,
    output logic [63:0]   w_out,
    output logic          w_valid,
    output logic [6:0]    round_idx,
    output logic          busy,
    output logic          done
);

`ifdef W_SCHED_SHA512_EN
    localparam int WW = W512_BITS;
`else
    localparam int WW = W256_BITS;
`endif

    state_t        state;
    logic          mode_q;
    logic          mode_eff;
    logic [6:0]    t;
    logic [6:0]    last_idx;
    logic [WW-1:0] win   [16];
    logic [WW-1:0] blk_w [16];
    logic [63:0]   s0_full;
    logic [63:0]   s1_full;
    logic [63:0]   s1_unused_a;
    logic [63:0]   s0_unused_b;
    logic [63:0]   sum64;
    logic [WW-1:0] w_next;
    logic          unused_bits;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
`ifdef W_SCHED_SHA512_EN
            if (mode_eff) begin
                blk_w[i] = block_in[1023 - 64*i -: 64];
            end else begin
                blk_w[i] = {32'b0, block_in[511 - 32*i -: 32]};
            end
`else
            blk_w[i] = block_in[511 - 32*i -: 32];
`endif
        end
    end

    w_sigma u_sigma0 (
        .word (64'(win[1])),
        .mode (mode_q),
        .s0   (s0_full),
        .s1   (s1_unused_a)
    );

    w_sigma u_sigma1 (
        .word (64'(win[14])),
        .mode (mode_q),
        .s0   (s0_unused_b),
        .s1   (s1_full)
    );

    assign sum64 = s1_full + 64'(win[9]) + s0_full + 64'(win[0]);

`ifdef W_SCHED_SHA512_EN
    assign mode_eff = mode;
    // SHA-256 words live in the low half; the sum can carry past bit 31
    assign w_next = mode_q ? sum64 : {32'b0, sum64[31:0]};
    assign unused_bits = ^{s1_unused_a, s0_unused_b};
`else
    assign mode_eff = 1'b0;
    assign w_next = sum64[31:0];
    assign unused_bits = ^{s1_unused_a, s0_unused_b, sum64[63:32], mode, block_in[1023:512]};
`endif

    assign last_idx = mode_q ? 7'(SHA512_ROUNDS - 1) : 7'(SHA256_ROUNDS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            t      <= '0;
            done   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= RUN;
                    mode_q <= mode_eff;
                    t      <= '0;
                    for (int i = 0; i < 16; i++) begin
                        win[i] <= blk_w[i];
                    end
                end
            end else if (w_ready) begin
                if (t == last_idx) begin
                    state <= IDLE;
                    done  <= 1'b1;
                    t     <= '0;
                end else begin
                    t <= t + 7'd1;
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i+1];
                    end
                    win[15] <= w_next;
                end
            end
        end
    end

    assign w_out     = 64'(win[0]);
    assign w_valid   = (state == RUN);
    assign busy      = (state == RUN);
    assign round_idx = t;

endmodule

// File: tb/tb_w_scheduler.sv
// Bench for w_scheduler: table of blocks run through a reference-schedule scoreboard.
module tb_w_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [1023:0] block_in;
    logic          w_ready;
    logic [63:0]   w_out;
    logic          w_valid;
    logic [6:0]    round_idx;
    logic          busy;
    logic          done;

    w_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .block_in  (block_in),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .w_valid   (w_valid),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic [1023:0] blk;
        int            stall_at;
        int            stall_len;
        int            inj_at;
        int            rst_at;
        logic          chk17;
        logic [63:0]   w16;
        logic [63:0]   w17;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] w;
    } sb_t;

    sb_t         exp_q [$];
    logic [63:0] ref_w [80];
    vec_t        tbl [6];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Textbook recurrence W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16
    task automatic gen_ref(input logic [1023:0] blk, input logic m);
        logic [63:0] a, b;
        logic [31:0] a32, b32;
        for (int i = 0; i < 80; i++) begin
            if (i < 16) begin
                ref_w[i] = m ? blk[1023 - 64*i -: 64] : {32'b0, blk[511 - 32*i -: 32]};
            end else if (m) begin
                a = ref_w[i-15];
                b = ref_w[i-2];
                ref_w[i] = (rr64(b, 19) ^ rr64(b, 61) ^ (b >> 6)) + ref_w[i-7]
                         + (rr64(a, 1) ^ rr64(a, 8) ^ (a >> 7)) + ref_w[i-16];
            end else begin
                a32 = ref_w[i-15][31:0];
                b32 = ref_w[i-2][31:0];
                ref_w[i] = {32'b0, (rr32(b32, 17) ^ rr32(b32, 19) ^ (b32 >> 10)) + ref_w[i-7][31:0]
                         + (rr32(a32, 7) ^ rr32(a32, 18) ^ (a32 >> 3)) + ref_w[i-16][31:0]};
            end
        end
    endtask

    task automatic run_block(input vec_t v);
        logic        m_eff;
        int          n;
        int          c;
        int          stalled;
        bit          injected;
        logic [63:0] got16;
        logic [63:0] got17;
        sb_t         e;
`ifdef W_SCHED_SHA512_EN
        m_eff = v.mode;
`else
        m_eff = 1'b0;
`endif
        n = m_eff ? 80 : 64;
        gen_ref(v.blk, m_eff);
        for (int i = 0; i < n; i++) exp_q.push_back('{i, ref_w[i]});

        start = 1'b1; mode = v.mode; block_in = v.blk; w_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("valid_after_start", 64'(w_valid), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);

        c = 1; stalled = 0; injected = 0; got16 = '0; got17 = '0;
        while (exp_q.size() > 0 && c < 400) begin
            start = 1'b0; block_in = v.blk; mode = v.mode; w_ready = 1'b1;
            if (exp_q[0].idx == v.rst_at) begin
                rst = 1'b1;
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                chk("rst_w_out", w_out, 64'd0);
                chk("rst_w_valid", 64'(w_valid), 64'd0);
                chk("rst_round_idx", 64'(round_idx), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                exp_q.delete();
                return;
            end
            if (exp_q[0].idx == v.stall_at && stalled < v.stall_len) begin
                w_ready = 1'b0;
                stalled++;
                chk("stall_hold_w", w_out, exp_q[0].w);
                chk("stall_hold_idx", 64'(round_idx), 64'(exp_q[0].idx));
            end
            if (exp_q[0].idx == v.inj_at && !injected) begin
                start = 1'b1; block_in = ~v.blk; mode = ~v.mode; injected = 1'b1;
            end
            if (w_ready && w_valid) begin
                e = exp_q.pop_front();
                chk("w_out", w_out, e.w);
                chk("round_idx", 64'(round_idx), 64'(e.idx));
                if (e.idx == 16) got16 = w_out;
                if (e.idx == 17) got17 = w_out;
            end
            @(posedge clk); @(negedge clk);
            c++;
        end
        chk("drained_in_budget", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("valid_at_done", 64'(w_valid), 64'd0);
        chk("done_cycle", 64'(c), 64'(n + 1 + v.stall_len));
        if (v.chk17) begin
            chk("w16", got16, v.w16);
            chk("w17", got17, v.w17);
        end
    endtask

    initial begin
        logic [1023:0] abc256, abc512, r1, r2;
        abc256 = '0; abc256[511:480] = 32'h61626380; abc256[31:0] = 32'h18;
        abc512 = '0; abc512[1023:960] = 64'h6162638000000000; abc512[63:0] = 64'h18;
        for (int i = 0; i < 32; i++) begin
            r1[i*32 +: 32] = $urandom();
            r2[i*32 +: 32] = $urandom();
        end
        tbl[0] = '{1'b0, abc256, -1, 0, -1, -1, 1'b1, 64'h61626380, 64'h000F0000};
`ifdef W_SCHED_SHA512_EN
        tbl[1] = '{1'b1, abc512, -1, 0, -1, -1, 1'b1, 64'h6162638000000000, 64'h00030000000000C0};
`else
        // mode ignored: low half of the 512-bit abc block run as SHA-256
        tbl[1] = '{1'b1, abc512, -1, 0, -1, -1, 1'b1, 64'h0, 64'h000F0000};
`endif
        tbl[2] = '{1'b0, abc256, 20, 3, -1, -1, 1'b1, 64'h61626380, 64'h000F0000};
        tbl[3] = '{1'b0, abc256, -1, 0, 10, -1, 1'b1, 64'h61626380, 64'h000F0000};
        tbl[4] = '{1'b0, r1, -1, 0, -1, 30, 1'b0, 64'h0, 64'h0};
        tbl[5] = '{1'b1, r2, 45, 2, 5, -1, 1'b0, 64'h0, 64'h0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; block_in = '0; w_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_w_out", w_out, 64'd0);
        chk("reset_w_valid", 64'(w_valid), 64'd0);
        chk("reset_round_idx", 64'(round_idx), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;

        // each row starts in the done cycle (or first post-reset cycle) of the previous one
        for (int i = 0; i < 6; i++) run_block(tbl[i]);

        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_all", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
